// File: rtl/pcieifc_fifo_ptr_sync.sv
// rtl/pcieifc_fifo_ptr_sync.sv - offset-gray pointer synchronizer with occupancy, threshold flags and step checking
module pcieifc_fifo_ptr_sync #(
  parameter int ADDR_WIDTH  = 5,
  parameter int FIFO_DEPTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int AF_LEVEL    = FIFO_DEPTH - 2,
  parameter int AE_LEVEL    = 2,
  parameter int DIR         = 1
) (
  input  logic                fifo_clk,
  input  logic                fifo_rstn,
  input  logic                fifo_clear,
  input  logic [ADDR_WIDTH:0] ptr_gray_in,
  input  logic [ADDR_WIDTH:0] ptr_bin_local,
  output logic [ADDR_WIDTH:0] ptr_bin_other,
  output logic [ADDR_WIDTH:0] level,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                other_moved,
  output logic                err_step
);

  localparam int OFFSET_I  = (1 << ADDR_WIDTH) - FIFO_DEPTH;
  localparam int BAND_HI_I = (2 << ADDR_WIDTH) - FIFO_DEPTH;

  localparam logic [ADDR_WIDTH:0]   DEPTH_P   = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   OFFSET_P  = (ADDR_WIDTH+1)'(OFFSET_I);
  localparam logic [ADDR_WIDTH:0]   BAND_HI_P = (ADDR_WIDTH+1)'(BAND_HI_I);
  localparam logic [ADDR_WIDTH:0]   AF_P      = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_P      = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   ONE_P     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH+1:0] DEPTH_W   = (ADDR_WIDTH+2)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_LOW  = ADDR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [2:0]            SETTLE    = 3'(SYNC_STAGES + 1);
  localparam bit                    HAS_BAND  = (FIFO_DEPTH < (1 << ADDR_WIDTH));

  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];

  logic [ADDR_WIDTH:0]   other_q, other_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  moved_q, moved_d;
  logic                  err_q, err_d;
  logic [2:0]            settle_q, settle_d;

  logic [ADDR_WIDTH:0]   raw_bin;
  logic [ADDR_WIDTH:0]   succ;
  logic [ADDR_WIDTH:0]   prod_p, cons_p;
  logic [ADDR_WIDTH+1:0] prod_low, cons_low, diff;
  logic                  sat, settled, step_bad, in_band;

  // Pure flop chain: nothing may sit between stages of a CDC synchronizer.
  always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
    if (!fifo_rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else if (fifo_clear) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ptr_gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    raw_bin = '0;
    raw_bin[ADDR_WIDTH] = sync_q[SYNC_STAGES-1][ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      raw_bin[i] = raw_bin[i+1] ^ sync_q[SYNC_STAGES-1][i];
    end
  end

  // Upper half of the pointer space was shifted up by the unused code band; undo it.
  assign other_d = (raw_bin > DEPTH_P) ? (raw_bin - OFFSET_P) : raw_bin;

  assign succ = (other_q[ADDR_WIDTH-1:0] == LAST_LOW) ?
                {~other_q[ADDR_WIDTH], {ADDR_WIDTH{1'b0}}} : (other_q + ONE_P);

  assign prod_p = (DIR != 0) ? ptr_bin_local : other_d;
  assign cons_p = (DIR != 0) ? other_d : ptr_bin_local;

  assign prod_low = {2'b00, prod_p[ADDR_WIDTH-1:0]};
  assign cons_low = {2'b00, cons_p[ADDR_WIDTH-1:0]};

  // One extra bit so a consumer ahead of the producer shows up as a huge value and saturates.
  assign diff = (prod_p[ADDR_WIDTH] == cons_p[ADDR_WIDTH]) ?
                (prod_low - cons_low) : (prod_low + DEPTH_W - cons_low);

  assign sat     = (diff > DEPTH_W);
  assign level_d = sat ? DEPTH_P : diff[ADDR_WIDTH:0];
  assign af_d    = (level_d >= AF_P);
  assign ae_d    = (level_d <= AE_P);
  assign moved_d = (other_d != other_q);

  assign settled  = (settle_q >= SETTLE);
  assign settle_d = settled ? settle_q : (settle_q + 3'd1);
  assign step_bad = settled && (other_d != other_q) && (other_d != succ);
  assign in_band  = HAS_BAND && (raw_bin >= DEPTH_P) && (raw_bin < BAND_HI_P);
  assign err_d    = err_q | step_bad | in_band | sat;

  always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
    if (!fifo_rstn) begin
      other_q  <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      moved_q  <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= 3'd0;
    end else if (fifo_clear) begin
      other_q  <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      moved_q  <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= 3'd0;
    end else begin
      other_q  <= other_d;
      level_q  <= level_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      moved_q  <= moved_d;
      err_q    <= err_d;
      settle_q <= settle_d;
    end
  end

  assign ptr_bin_other = other_q;
  assign level         = level_q;
  assign almost_full   = af_q;
  assign almost_empty  = ae_q;
  assign other_moved   = moved_q;
  assign err_step      = err_q;

endmodule

// File: tb/tb_pcieifc_fifo_ptr_sync.sv
// tb/tb_pcieifc_fifo_ptr_sync.sv - self-checking bench for pcieifc_fifo_ptr_sync
`timescale 1ns/1ps
module tb_pcieifc_fifo_ptr_sync;

  localparam int S  = 2;
  localparam int NR = 500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn0, clr0, rstn1, clr1;
  logic [5:0] gin0, loc0, oth0, lvl0;
  logic       af0, ae0, mv0, er0;
  logic [4:0] gin1, loc1, oth1, lvl1;
  logic       af1, ae1, mv1, er1;

  pcieifc_fifo_ptr_sync #(.ADDR_WIDTH(5), .FIFO_DEPTH(32), .SYNC_STAGES(S), .DIR(1)) dut0 (
    .fifo_clk(clk), .fifo_rstn(rstn0), .fifo_clear(clr0),
    .ptr_gray_in(gin0), .ptr_bin_local(loc0), .ptr_bin_other(oth0), .level(lvl0),
    .almost_full(af0), .almost_empty(ae0), .other_moved(mv0), .err_step(er0));

  pcieifc_fifo_ptr_sync #(.ADDR_WIDTH(4), .FIFO_DEPTH(12), .SYNC_STAGES(S), .DIR(0)) dut1 (
    .fifo_clk(clk), .fifo_rstn(rstn1), .fifo_clear(clr1),
    .ptr_gray_in(gin1), .ptr_bin_local(loc1), .ptr_bin_other(oth1), .level(lvl1),
    .almost_full(af1), .almost_empty(ae1), .other_moved(mv1), .err_step(er1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Linear position 0..2D-1 of a pointer around the doubled ring.
  function automatic int idx_of(input int p, input int aw, input int d);
    return ((p >> aw) & 1) * d + (p & ((1 << aw) - 1));
  endfunction

  function automatic int ptr_of(input int i, input int aw, input int d);
    return ((i >= d) ? (1 << aw) : 0) + (i % d);
  endfunction

  function automatic int graw(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int enc(input int p, input int aw, input int d);
    int low, b;
    low = p & ((1 << aw) - 1);
    b = ((p >> aw) & 1) ? ((2 << aw) - d + low) : low;
    return graw(b);
  endfunction

  typedef struct {
    int loc;
    int oth;
    int lvl;
    int af;
    int ae;
  } vec_t;

  vec_t tbl [12];

  int aw_c  [2] = '{5, 4};
  int dd_c  [2] = '{32, 12};
  int dir_c [2] = '{1, 0};
  int af_c  [2] = '{30, 10};

  int drv [2][0:NR];
  int lcl [2][0:NR];
  int cur [2];
  int rst_e [2];
  int m_prev [2];
  int m_lvl [2];
  int m_af [2];
  int m_ae [2];
  int m_mv [2];
  int m_err [2];

  task automatic model_edge(input int k, input int e, input bit clr);
    int nw, pi, ci, lv, d, aw;
    d  = dd_c[k];
    aw = aw_c[k];
    if (clr) begin
      rst_e[k] = e; m_prev[k] = 0; m_lvl[k] = 0; m_af[k] = 0;
      m_ae[k] = 1;  m_mv[k] = 0;   m_err[k] = 0;
    end else begin
      nw = (e - S > rst_e[k]) ? drv[k][e-S] : 0;
      if ((e - rst_e[k] >= S + 2) && (nw != m_prev[k]) &&
          (idx_of(nw, aw, d) != (idx_of(m_prev[k], aw, d) + 1) % (2 * d)))
        m_err[k] = 1;
      if (dir_c[k] != 0) begin
        pi = idx_of(lcl[k][e], aw, d);
        ci = idx_of(nw, aw, d);
      end else begin
        pi = idx_of(nw, aw, d);
        ci = idx_of(lcl[k][e], aw, d);
      end
      lv = (pi - ci + 2 * d) % (2 * d);
      if (lv > d) begin
        lv = d;
        m_err[k] = 1;
      end
      m_mv[k]   = (nw != m_prev[k]) ? 1 : 0;
      m_prev[k] = nw;
      m_lvl[k]  = lv;
      m_af[k]   = (lv >= af_c[k]) ? 1 : 0;
      m_ae[k]   = (lv <= 2) ? 1 : 0;
    end
  endtask

  initial begin
    int mv_cnt, prev, r, rr, li, d;
    bit c;
    int seq [$];

    tbl[0]  = '{33, 31,  2, 0, 1};
    tbl[1]  = '{62, 31, 31, 1, 0};
    tbl[2]  = '{32, 31,  1, 0, 1};
    tbl[3]  = '{ 7,  7,  0, 0, 1};
    tbl[4]  = '{37,  5, 32, 1, 0};
    tbl[5]  = '{ 9,  5,  4, 0, 0};
    tbl[6]  = '{20, 10, 10, 0, 0};
    tbl[7]  = '{ 3, 10, 32, 1, 0};
    tbl[8]  = '{40, 10, 30, 1, 0};
    tbl[9]  = '{13, 10,  3, 0, 0};
    tbl[10] = '{12, 10,  2, 0, 1};
    tbl[11] = '{60, 31, 29, 0, 0};

    rstn0 = 1'b0; rstn1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    gin0 = 6'(enc(5, 5, 32)); loc0 = 6'd9;
    gin1 = '0; loc1 = '0;
    repeat (2) tick();
    chk("rst other", int'(oth0), 0);
    chk("rst level", int'(lvl0), 0);
    chk("rst af", int'(af0), 0);
    chk("rst ae", int'(ae0), 1);
    chk("rst moved", int'(mv0), 0);
    chk("rst err", int'(er0), 0);
    chk("rst1 ae", int'(ae1), 1);

    // first capture after reset: latency and single moved pulse
    rstn0 = 1'b1; rstn1 = 1'b1;
    mv_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      mv_cnt += int'(mv0);
      if (i == 2) chk("lat edge2 other", int'(oth0), 0);
      if (i == 3) begin
        chk("lat edge3 other", int'(oth0), 5);
        chk("lat edge3 moved", int'(mv0), 1);
        chk("lat level", int'(lvl0), 4);
        chk("lat ae", int'(ae0), 0);
        chk("lat af", int'(af0), 0);
      end
    end
    chk("moved pulses", mv_cnt, 1);
    chk("first step err", int'(er0), 0);

    for (int i = 0; i < 12; i++) begin
      gin0 = 6'(enc(tbl[i].oth, 5, 32));
      loc0 = 6'(tbl[i].loc);
      repeat (4) tick();
      chk($sformatf("tbl%0d other", i), int'(oth0), tbl[i].oth);
      chk($sformatf("tbl%0d level", i), int'(lvl0), tbl[i].lvl);
      chk($sformatf("tbl%0d af", i), int'(af0), tbl[i].af);
      chk($sformatf("tbl%0d ae", i), int'(ae0), tbl[i].ae);
    end

    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("clr other", int'(oth0), 0);
    chk("clr level", int'(lvl0), 0);
    chk("clr af", int'(af0), 0);
    chk("clr ae", int'(ae0), 1);
    chk("clr moved", int'(mv0), 0);
    chk("clr err", int'(er0), 0);

    // two-step jump must flag exactly at the capture edge and stay set
    gin0 = 6'(enc(3, 5, 32)); loc0 = 6'd3;
    repeat (6) tick();
    chk("jump pre err", int'(er0), 0);
    chk("jump pre other", int'(oth0), 3);
    gin0 = 6'(enc(6, 5, 32)); loc0 = 6'd6;
    repeat (2) tick();
    chk("jump edge2 err", int'(er0), 0);
    tick();
    chk("jump edge3 err", int'(er0), 1);
    chk("jump edge3 other", int'(oth0), 6);
    gin0 = 6'(enc(7, 5, 32)); loc0 = 6'd7;
    repeat (3) tick();
    chk("jump sticky err", int'(er0), 1);
    clr0 = 1'b1; tick(); clr0 = 1'b0;
    chk("jump clr err", int'(er0), 0);
    repeat (4) tick();
    chk("post clr other", int'(oth0), 7);
    chk("post clr err", int'(er0), 0);

    // asynchronous reset mid-traffic
    gin0 = 6'(enc(8, 5, 32)); loc0 = 6'd25;
    repeat (5) tick();
    chk("pre arst level", int'(lvl0), 17);
    chk("pre arst err", int'(er0), 0);
    #3;
    rstn0 = 1'b0;
    #1;
    chk("arst other", int'(oth0), 0);
    chk("arst level", int'(lvl0), 0);
    chk("arst af", int'(af0), 0);
    chk("arst ae", int'(ae0), 1);
    chk("arst moved", int'(mv0), 0);
    chk("arst err", int'(er0), 0);
    tick();
    rstn0 = 1'b1;
    repeat (3) tick();
    chk("rel other", int'(oth0), 8);
    chk("rel err", int'(er0), 0);
    repeat (3) tick();
    chk("rel late err", int'(er0), 0);
    chk("rel level", int'(lvl0), 17);

    // non-power-of-two depth: walk the whole ring including the wrap
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    for (int v = 0; v < 12; v++) seq.push_back(v);
    for (int v = 16; v < 28; v++) seq.push_back(v);
    seq.push_back(0);
    prev = 0;
    for (int i = 0; i < seq.size(); i++) begin
      gin1 = 5'(enc(seq[i], 4, 12));
      loc1 = 5'(prev);
      repeat (4) tick();
      chk($sformatf("walk%0d other", i), int'(oth1), seq[i]);
      chk($sformatf("walk%0d err", i), int'(er1), 0);
      chk($sformatf("walk%0d level", i), int'(lvl1), (i == 0) ? 0 : 1);
      prev = seq[i];
    end

    // raw code from the unused band decodes to the held pointer but must still flag
    clr1 = 1'b1; tick(); clr1 = 1'b0;
    gin1 = 5'(enc(11, 4, 12)); loc1 = 5'd0;
    repeat (6) tick();
    chk("band pre err", int'(er1), 0);
    chk("band pre other", int'(oth1), 11);
    gin1 = 5'(graw(15));
    repeat (2) tick();
    chk("band edge2 err", int'(er1), 0);
    tick();
    chk("band err", int'(er1), 1);
    chk("band other", int'(oth1), 11);

    cur[0] = 0; cur[1] = 0;
    for (int e = 0; e <= NR; e++) begin
      c = (e % 97 == 0);
      for (int k = 0; k < 2; k++) begin
        d = dd_c[k];
        r = int'($urandom_range(0, 99));
        if (r >= 98) cur[k] = int'($urandom_range(0, 2 * d - 1));
        else if (r >= 50) cur[k] = (cur[k] + 1) % (2 * d);
        if (dir_c[k] != 0) begin
          rr = int'($urandom_range(0, d));
          li = (cur[k] + rr) % (2 * d);
        end else begin
          rr = int'($urandom_range(3, d));
          li = (cur[k] - rr + 2 * d) % (2 * d);
        end
        drv[k][e] = ptr_of(cur[k], aw_c[k], d);
        lcl[k][e] = ptr_of(li, aw_c[k], d);
      end
      gin0 = 6'(enc(drv[0][e], 5, 32)); loc0 = 6'(lcl[0][e]); clr0 = c;
      gin1 = 5'(enc(drv[1][e], 4, 12)); loc1 = 5'(lcl[1][e]); clr1 = c;
      @(posedge clk);
      model_edge(0, e, c);
      model_edge(1, e, c);
      #1;
      chk("rnd0 other", int'(oth0), m_prev[0]);
      chk("rnd0 level", int'(lvl0), m_lvl[0]);
      chk("rnd0 af", int'(af0), m_af[0]);
      chk("rnd0 ae", int'(ae0), m_ae[0]);
      chk("rnd0 moved", int'(mv0), m_mv[0]);
      chk("rnd0 err", int'(er0), m_err[0]);
      chk("rnd1 other", int'(oth1), m_prev[1]);
      chk("rnd1 level", int'(lvl1), m_lvl[1]);
      chk("rnd1 af", int'(af1), m_af[1]);
      chk("rnd1 ae", int'(ae1), m_ae[1]);
      chk("rnd1 moved", int'(mv1), m_mv[1]);
      chk("rnd1 err", int'(er1), m_err[1]);
    end
    clr0 = 1'b0; clr1 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcieifc_fifo_ptr_sync.md
PCIEIFC_FIFO_PTR_SYNC -- requirements
Module: pcieifc_fifo_ptr_sync

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 5, pointer address width.
- FIFO_DEPTH, default 32, actual entry count, 2 <= FIFO_DEPTH <= 2^ADDR_WIDTH.
- SYNC_STAGES, default 2, synchronizer flop count, range 2..4.
- AF_LEVEL, default FIFO_DEPTH-2, almost-full threshold.
- AE_LEVEL, default 2, almost-empty threshold.
- DIR, default 1: 1 = instance lives in the write domain (local = producer); 0 = read domain (local = consumer).
REQ-002 Ports SHALL be:
- fifo_clk  in  1  clock of the local domain.
- fifo_rstn  in  1  reset, asynchronous, active-low.
- fifo_clear  in  1  synchronous clear, active high.
- ptr_gray_in  in  ADDR_WIDTH+1  offset-gray pointer launched from the other clock domain.
- ptr_bin_local  in  ADDR_WIDTH+1  local binary pointer.
- ptr_bin_other  out  ADDR_WIDTH+1  registered binary pointer of the other domain.
- level  out  ADDR_WIDTH+1  registered FIFO occupancy.
- almost_full  out  1  registered, level >= AF_LEVEL.
- almost_empty  out  1  registered, level <= AE_LEVEL.
- other_moved  out  1  one-cycle pulse when ptr_bin_other changes.
- err_step  out  1  sticky error: the other pointer advanced more than one step.

Function
REQ-003 Pointer space: low field 0..FIFO_DEPTH-1 plus a wrap bit (MSB). Successor of a pointer with low field FIFO_DEPTH-1 SHALL be {~MSB, 0}; otherwise successor = pointer+1.
REQ-004 Decode SHALL be combinational on the last sync stage: b = standard gray-to-binary(g). Result = b - (2^ADDR_WIDTH - FIFO_DEPTH) if b > FIFO_DEPTH, else b.
REQ-005 ptr_gray_in SHALL pass through SYNC_STAGES flops with no logic between them. No combinational path SHALL exist from ptr_gray_in to any output.
REQ-006 At each clock edge, ptr_bin_other SHALL load decode(last sync stage). Latency from ptr_gray_in change to ptr_bin_other = SYNC_STAGES+1 edges.
REQ-007 Define producer pointer P and consumer pointer C:
- DIR=1: P = ptr_bin_local, C = decoded pointer.
- DIR=0: P = decoded pointer, C = ptr_bin_local.
REQ-008 Level calculation, with width ADDR_WIDTH+1 and no overflow:
- If P[MSB] == C[MSB]: level_next = P_low - C_low.
- Otherwise: level_next = P_low + FIFO_DEPTH - C_low.
REQ-009 level, almost_full and almost_empty SHALL register at the same edge as ptr_bin_other. They use ptr_bin_local as sampled at that edge.
REQ-010 other_moved SHALL be 1 for exactly the cycle after an edge where the new ptr_bin_other differs from the old value.
REQ-011 When the new decoded value is neither the old value nor its successor per REQ-003, err_step SHALL set to 1 and hold until reset or fifo_clear.
REQ-012 A decoded value of exactly 2^ADDR_WIDTH - FIFO_DEPTH + FIFO_DEPTH... i.e. any raw b in the removed gray band SHALL also set err_step. This check applies only when FIFO_DEPTH < 2^ADDR_WIDTH.
REQ-013 Level saturation: if level_next > FIFO_DEPTH (corrupt pointer), level SHALL load FIFO_DEPTH and err_step SHALL set.
REQ-014 Wrap: P={1,0}, C={0,FIFO_DEPTH-1} SHALL give level=1. P == C SHALL give level 0. Equal low fields with opposite MSB SHALL give level FIFO_DEPTH.

Reset
REQ-015 On fifo_rstn low, immediately clear to 0: all sync stages, ptr_bin_other, level, almost_full, other_moved, err_step. almost_empty SHALL be 1.
REQ-016 fifo_clear SHALL force the same values as REQ-015 at the next edge and take priority over all updates.
REQ-017 Reset deassertion mid-traffic: the first post-reset step from 0 to any captured pointer SHALL NOT set err_step. The step check is disabled until SYNC_STAGES+1 edges after reset or clear.

Verification
REQ-018 DIR=1, defaults. Hold ptr_gray_in=gray(5) and ptr_bin_local=9. Expect ptr_bin_other=5 at edge 3, level=4, other_moved pulse once, almost_empty=0.
REQ-019 FIFO_DEPTH=12, ADDR_WIDTH=4. Step the other pointer through 0..11, then 16..27, via the offset-gray code. ptr_bin_other SHALL track each value and err_step SHALL stay 0.
REQ-020 DIR=1, defaults. ptr_bin_local={1,00001}, other pointer {0,11111}. Expect level=2, almost_empty=1. Set local to {1,11110}: expect level=31, almost_full=1.
REQ-021 Jump ptr_gray_in from gray(3) to gray(6) -> err_step=1 three edges later and sticky. Assert fifo_clear -> err_step=0 at the next edge.
REQ-022 Assert fifo_rstn low asynchronously while level=17 -> all outputs take reset values with no clock edge. Release with ptr_gray_in=gray(8) -> ptr_bin_other=8 and err_step=0.
